// File: rtl/cdb_pkg.sv
// Shared constants, source-index encoding and helpers for the common data bus arbiter.
package cdb_pkg;

    localparam int unsigned TAG_W_DEF  = 5;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 32;

    localparam logic [TAG_W_DEF-1:0] NO_TAG_DEF = 5'b10000;

    // Width of the cdb_src side-band; wide enough for up to eight producers.
    localparam int unsigned SRC_IDX_W = 3;

    typedef enum logic [SRC_IDX_W-1:0] {
        SRC_ALU = 3'd0,
        SRC_BRA = 3'd1,
        SRC_LSM = 3'd2
    } src_id_e;

    function automatic int unsigned src_idx_w(input int unsigned num_src);
        return (num_src <= 1) ? 1 : $clog2(num_src);
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side and broadcast-side signal bundle of the common data bus arbiter.
interface cdb_arbiter_if import cdb_pkg::*; #(
    parameter int unsigned NUM_SRC   = 3,
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned TAG_W     = TAG_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
);

    logic [NUM_SRC-1:0]             src_valid;
    logic [NUM_SRC-1:0]             src_ready;
    logic [NUM_SRC*TAG_W-1:0]       src_tag;
    logic [NUM_SRC*DATA_W-1:0]      src_data;
    logic [NUM_SRC*ADDR_W-1:0]      src_addr;

    logic [NUM_LANES-1:0]           cdb_valid;
    logic [NUM_LANES*TAG_W-1:0]     cdb_tag;
    logic [NUM_LANES*DATA_W-1:0]    cdb_data;
    logic [NUM_LANES*ADDR_W-1:0]    cdb_addr;
    logic [NUM_LANES*SRC_IDX_W-1:0] cdb_src;

    modport master (
        output src_valid, src_tag, src_data, src_addr,
        input  src_ready, cdb_valid, cdb_tag, cdb_data, cdb_addr, cdb_src
    );

    modport slave (
        input  src_valid, src_tag, src_data, src_addr,
        output src_ready, cdb_valid, cdb_tag, cdb_data, cdb_addr, cdb_src
    );

endinterface

// File: rtl/cdb_src_fifo.sv
// Per-producer result FIFO: registered count, no bypass, flush empties it.
module cdb_src_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    // Full blocks a push even when the same edge pops; flush drops both.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Buffered multi-lane common data bus: per-source FIFOs, round-robin lane grant, registered
// broadcast with flush on mispredict.
module cdb_arbiter import cdb_pkg::*; #(
    parameter int unsigned      NUM_SRC    = 3,
    parameter int unsigned      NUM_LANES  = 2,
    parameter int unsigned      TAG_W      = TAG_W_DEF,
    parameter int unsigned      DATA_W     = DATA_W_DEF,
    parameter int unsigned      ADDR_W     = ADDR_W_DEF,
    parameter int unsigned      FIFO_DEPTH = 2,
    parameter logic [TAG_W-1:0] NO_TAG     = TAG_W'(NO_TAG_DEF)
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    cdb_arbiter_if.slave bus
);

    localparam int unsigned ENT_W  = TAG_W + DATA_W + ADDR_W;
    localparam int unsigned PTR_W  = src_idx_w(NUM_SRC);
    localparam int unsigned LANE_W = src_idx_w(NUM_LANES);

    logic [NUM_SRC-1:0][TAG_W-1:0]  src_tag;
    logic [NUM_SRC-1:0][DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0][ADDR_W-1:0] src_addr;
    logic [NUM_SRC-1:0][ENT_W-1:0]  head;
    logic [NUM_SRC-1:0]             full, empty, push, grant;

    logic [PTR_W-1:0] rr_q, rr_d;
    logic [PTR_W:0]   scan;
    logic [PTR_W-1:0] idx;
    logic [LANE_W:0]  n_grant;

    logic [NUM_LANES-1:0]                valid_q, valid_d;
    logic [NUM_LANES-1:0][TAG_W-1:0]     tag_q, tag_d;
    logic [NUM_LANES-1:0][DATA_W-1:0]    data_q, data_d;
    logic [NUM_LANES-1:0][ADDR_W-1:0]    addr_q, addr_d;
    logic [NUM_LANES-1:0][SRC_IDX_W-1:0] src_q, src_d;

    assign src_tag       = bus.src_tag;
    assign src_data      = bus.src_data;
    assign src_addr      = bus.src_addr;
    assign push          = bus.src_valid & ~full;
    assign bus.src_ready = ~full;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_fifo
        cdb_src_fifo #(
            .WIDTH (ENT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[s]),
            .pop   (grant[s]),
            .wdata ({src_tag[s], src_data[s], src_addr[s]}),
            .full  (full[s]),
            .empty (empty[s]),
            .head  (head[s])
        );
    end

    // Scan from rr_q with modular wrap; the k-th non-empty source fills lane k.
    always_comb begin
        grant   = '0;
        rr_d    = rr_q;
        n_grant = '0;
        scan    = '0;
        idx     = '0;
        valid_d = '0;
        tag_d   = {NUM_LANES{NO_TAG}};
        data_d  = '0;
        addr_d  = '0;
        src_d   = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            scan = {1'b0, rr_q} + (PTR_W + 1)'(k);
            if (scan >= (PTR_W + 1)'(NUM_SRC)) scan = scan - (PTR_W + 1)'(NUM_SRC);
            idx = scan[PTR_W-1:0];
            if (!empty[idx] && (n_grant < (LANE_W + 1)'(NUM_LANES))) begin
                grant[idx] = 1'b1;
                valid_d[n_grant[LANE_W-1:0]] = 1'b1;
                {tag_d[n_grant[LANE_W-1:0]], data_d[n_grant[LANE_W-1:0]],
                 addr_d[n_grant[LANE_W-1:0]]} = head[idx];
                src_d[n_grant[LANE_W-1:0]] = SRC_IDX_W'(idx);
                rr_d = (idx == PTR_W'(NUM_SRC - 1)) ? '0 : idx + PTR_W'(1);
                n_grant = n_grant + (LANE_W + 1)'(1);
            end
        end
        if (flush) begin
            grant   = '0;
            rr_d    = rr_q;
            valid_d = '0;
            tag_d   = {NUM_LANES{NO_TAG}};
            data_d  = '0;
            addr_d  = '0;
            src_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q    <= '0;
            valid_q <= '0;
            tag_q   <= {NUM_LANES{NO_TAG}};
            data_q  <= '0;
            addr_q  <= '0;
            src_q   <= '0;
        end else begin
            rr_q    <= rr_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            src_q   <= src_d;
        end
    end

    assign bus.cdb_valid = valid_q;
    assign bus.cdb_tag   = tag_q;
    assign bus.cdb_data  = data_q;
    assign bus.cdb_addr  = addr_q;
    assign bus.cdb_src   = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts every broadcast
// cycle, a separate monitor compares the DUT against the predictions.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NS    = 3;
    localparam int NL    = 2;
    localparam int TW    = 5;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic [2:0]    src;
    } ent_t;

    typedef struct packed {
        logic [NL-1:0]          valid;
        logic [NL-1:0][TW-1:0]  tag;
        logic [NL-1:0][DW-1:0]  data;
        logic [NL-1:0][AW-1:0]  addr;
        logic [NL-1:0][2:0]     src;
    } bcast_t;

    logic clk;
    logic rst;
    logic flush;

    int n_tests;
    int n_fail;

    ent_t   mq [NS][$];
    bcast_t exp_q [$];
    int     rr_m;

    // Model scratch, only touched by the model process.
    bcast_t m_rec;
    ent_t   m_e;
    int     m_sz [NS];
    int     m_used;
    int     m_start;
    int     m_s;

    bcast_t            mon_rec;
    logic [NS-1:0]     mon_rdy;
    logic [NL-1:0][TW-1:0] idle_tag;

    cdb_arbiter_if #(
        .NUM_SRC   (NS),
        .NUM_LANES (NL),
        .TAG_W     (TW),
        .DATA_W    (DW),
        .ADDR_W    (AW)
    ) bus ();

    cdb_arbiter #(
        .NUM_SRC    (NS),
        .NUM_LANES  (NL),
        .TAG_W      (TW),
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, 128'(bus.cdb_valid), 128'(0));
        check({name, "_tag"},   128'(bus.cdb_tag),   128'(idle_tag));
        check({name, "_data"},  128'(bus.cdb_data),  128'(0));
        check({name, "_addr"},  128'(bus.cdb_addr),  128'(0));
        check({name, "_src"},   128'(bus.cdb_src),   128'(0));
        check({name, "_ready"}, 128'(bus.src_ready), 128'({NS{1'b1}}));
    endtask

    task automatic drive(input logic [NS-1:0] v, input logic fl);
        @(posedge clk);
        #1;
        bus.src_valid = v;
        flush = fl;
        for (int s = 0; s < NS; s++) begin
            bus.src_tag[s*TW +: TW]  = TW'($urandom);
            bus.src_data[s*DW +: DW] = $urandom;
            bus.src_addr[s*AW +: AW] = $urandom;
        end
    endtask

    // Reference model: per-source queues, round-robin pointer, one predicted record per edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NS; s++) mq[s].delete();
            exp_q.delete();
            rr_m = 0;
        end else begin
            m_rec.valid = '0;
            m_rec.tag   = {NL{NO_TAG_DEF}};
            m_rec.data  = '0;
            m_rec.addr  = '0;
            m_rec.src   = '0;
            if (flush) begin
                for (int s = 0; s < NS; s++) mq[s].delete();
            end else begin
                for (int s = 0; s < NS; s++) m_sz[s] = mq[s].size();
                m_used  = 0;
                m_start = rr_m;
                for (int k = 0; k < NS; k++) begin
                    m_s = (m_start + k) % NS;
                    if (m_used < NL && mq[m_s].size() > 0) begin
                        m_e = mq[m_s].pop_front();
                        m_rec.valid[m_used] = 1'b1;
                        m_rec.tag[m_used]   = m_e.tag;
                        m_rec.data[m_used]  = m_e.data;
                        m_rec.addr[m_used]  = m_e.addr;
                        m_rec.src[m_used]   = m_e.src;
                        m_used++;
                        rr_m = (m_s + 1) % NS;
                    end
                end
                for (int s = 0; s < NS; s++) begin
                    if (bus.src_valid[s] && m_sz[s] < DEPTH) begin
                        m_e.tag  = bus.src_tag[s*TW +: TW];
                        m_e.data = bus.src_data[s*DW +: DW];
                        m_e.addr = bus.src_addr[s*AW +: AW];
                        m_e.src  = 3'(s);
                        mq[s].push_back(m_e);
                    end
                end
            end
            exp_q.push_back(m_rec);
        end
    end

    // Monitor: compares the DUT broadcast and ready against the predicted record each cycle.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_empty: got no prediction expected one at %0t", $time);
            end else begin
                mon_rec = exp_q.pop_front();
                check("cdb_valid", 128'(bus.cdb_valid), 128'(mon_rec.valid));
                check("cdb_tag",   128'(bus.cdb_tag),   128'(mon_rec.tag));
                check("cdb_data",  128'(bus.cdb_data),  128'(mon_rec.data));
                check("cdb_addr",  128'(bus.cdb_addr),  128'(mon_rec.addr));
                check("cdb_src",   128'(bus.cdb_src),   128'(mon_rec.src));
            end
            for (int s = 0; s < NS; s++) mon_rdy[s] = (mq[s].size() < DEPTH);
            check("src_ready", 128'(bus.src_ready), 128'(mon_rdy));
        end
    end

    initial begin
        logic [NS-1:0] v;
        logic          fl;
        bit            found;

        n_tests       = 0;
        n_fail        = 0;
        idle_tag      = {NL{NO_TAG_DEF}};
        rst           = 1'b0;
        flush         = 1'b0;
        bus.src_valid = '0;
        bus.src_tag   = '0;
        bus.src_data  = '0;
        bus.src_addr  = '0;

        repeat (2) @(negedge clk);
        check_idle("reset");
        #1 rst = 1'b1;

        // Single push from source 0.
        drive(3'b001, 1'b0);
        bus.src_tag[0 +: TW]  = 5'd3;
        bus.src_data[0 +: DW] = 32'h11;
        repeat (4) drive(3'b000, 1'b0);

        // All three sources contend once.
        drive(3'b111, 1'b0);
        repeat (4) drive(3'b000, 1'b0);

        // Fill FIFOs under contention, then flush with pushes present.
        repeat (5) drive(3'b111, 1'b0);
        drive(3'b111, 1'b1);
        repeat (3) drive(3'b000, 1'b0);

        // Only sources 0 and 2 active, exercises the wrap of the scan.
        repeat (8) drive(3'b101, 1'b0);
        repeat (4) drive(3'b000, 1'b0);

        // Randomised traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            for (int s = 0; s < NS; s++) v[s] = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 24) == 0);
            drive(v, fl);
        end
        drive(3'b000, 1'b0);

        // Asynchronous reset while both lanes broadcast.
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            drive(3'b111, 1'b0);
            if (bus.cdb_valid == 2'b11) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL dual_lane_wait: got no cdb_valid=11 expected one within 50 cycles");
        end
        #1 rst = 1'b0;
        #1 check_idle("async_reset");
        @(negedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 100; i++) begin
            for (int s = 0; s < NS; s++) v[s] = ($urandom_range(0, 1) != 0);
            drive(v, 1'b0);
        end
        repeat (6) drive(3'b000, 1'b0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
